id_issue_ctrl: RTL and testbench
================================

// Module: id_issue_ctrl
// PURPOSE
//  Sequences decoded instructions through id_stage_2 and issues them to execute.
//  Latches one instruction from fetch and drives it onto id_stage_2.
//  Stalls on register/flag hazards using an 8-bit busy scoreboard.
//  Holds the MMU request for memory ops (opcode[23:21]==3'b001), then issues downstream.
// PARAMETERS
//  INSTR_W      24   instruction width
//  NREGS        8    architectural registers tracked (scoreboard width)
//  MMU_TIMEOUT  255  max cycles in MMU_WAIT before error
// PORTS
//  clk            in   1       clock, all logic on rising edge
//  rst_n          in   1       synchronous reset, active low
//  in_valid       in   1       fetch offers instruction
//  in_instr       in   INSTR_W instruction from fetch
//  in_src_mask    in   NREGS   registers read by in_instr
//  in_ready       out  1       controller accepts instruction this cycle
//  ds2_instr      out  INSTR_W instruction driven to id_stage_2
//  ds2_ready      in   1       id_stage_2 instruction_ready
//  ds2_finished   in   1       id_stage_2 instruction_finished
//  ds2_flags      in   1       id_stage_2 setting_flags
//  ds2_regs_set   in   NREGS   id_stage_2 registers_set
//  mmu_req        out  1       MMU access request (to id_stage_2 mmu_ready source)
//  issue_valid    out  1       instruction offered to execute
//  issue_ready    in   1       execute accepts
//  issue_instr    out  INSTR_W issued instruction
//  wb_valid       in   1       writeback this cycle
//  wb_mask        in   NREGS   registers written back
//  wb_flags       in   1       flags written back
//  busy_mask      out  NREGS   scoreboard: registers with pending writes
//  stall          out  1       hazard stall in CHECK
//  retire         out  1       one-cycle pulse: instruction finished in decode
//  mmu_err        out  1       sticky MMU timeout
// BEHAVIOUR
//  Reset (rst_n=0 at edge): state=IDLE, instr_q=0, src_q=0, busy_mask=0, flags_busy=0,
//   tmo_cnt=0, mmu_err=0. All outputs 0 except in_ready=1. Reset mid-operation aborts
//   any instruction, drops mmu_req, and clears the scoreboard.
//  ds2_instr=instr_q at all times; issue_instr=instr_q.
//  FSM states are IDLE, CHECK, MMU_WAIT, ISSUE and ERROR.
//  IDLE: in_ready=1. When in_valid=1, latch in_instr->instr_q and in_src_mask->src_q, then go to CHECK.
//  CHECK: hazard = |(src_q&busy_mask) | |(ds2_regs_set&busy_mask) | (ds2_flags&flags_busy).
//   If hazard=1: stall=1 and stay in CHECK.
//   Else if ds2_finished=1: retire=1 and go to IDLE.
//   Else if instr_q[23:21]==3'b001: go to MMU_WAIT with tmo_cnt=0.
//   Else go to ISSUE.
//  MMU_WAIT: mmu_req=1.
//   If ds2_ready=1 and ds2_finished=1: retire=1 and go to IDLE.
//   If ds2_ready=1 and ds2_finished=0: go to ISSUE.
//   Else tmo_cnt++. When tmo_cnt==MMU_TIMEOUT-1 and ds2_ready=0: go to ERROR.
//  ISSUE: issue_valid=1 and held until issue_ready (valid/instr stable while waiting).
//   On handshake: busy_mask|=ds2_regs_set, flags_busy|=ds2_flags, then go to IDLE.
//  ERROR: mmu_err=1 and mmu_req=0. Only reset leaves ERROR.
//  Scoreboard each cycle: busy_next=(busy|set)&~(wb_valid?wb_mask:0)|set, so the set wins
//   when the same bit is set and cleared in one cycle; flags are handled the same way with wb_flags.
//  Writeback is honoured in every state, including while stalled, so a stalled CHECK
//   re-evaluates next cycle.
//  Throughput: max 1 instruction per 3 cycles (IDLE->CHECK->ISSUE), plus MMU/hazard waits.
// TESTING
//  ALU op 0x812300, ds2_regs_set=0x23, busy=0, issue_ready=1 -> issue_valid at cycle 2 after accept;
//   busy_mask=0x23 after handshake.
//  Next instr src_mask=0x02 while busy=0x23 -> stall=1. Then wb_valid=1, wb_mask=0x02 ->
//   stall drops next cycle; issue follows.
//  Memory op 0x2xxxxx, ds2_ready low 5 cycles then high -> mmu_req=1 for 6 cycles, then
//   issue_valid; opcode 0x3xxxxx with ds2_finished -> retire pulse, no issue_valid.
//  ds2_ready held 0 -> mmu_err=1 after MMU_TIMEOUT cycles, FSM stays ERROR, in_ready=0.
//   rst_n=0 for 1 cycle -> all cleared, in_ready=1.
//  Same cycle: issue handshake sets bit 4 and wb_mask=0x10 -> busy bit 4 remains 1.
//   Opcode 0x0xxxxx -> retire from CHECK, busy unchanged.

Source files
------------

// File: rtl/id_issue_ctrl.sv
// id_issue_ctrl: latches a fetched instruction, stalls on scoreboard hazards, holds MMU requests and issues to execute
module id_issue_ctrl #(
  parameter int INSTR_W = 24,
  parameter int NREGS = 8,
  parameter int MMU_TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic [NREGS-1:0]   in_src_mask,
  output logic               in_ready,
  output logic [INSTR_W-1:0] ds2_instr,
  input  logic               ds2_ready,
  input  logic               ds2_finished,
  input  logic               ds2_flags,
  input  logic [NREGS-1:0]   ds2_regs_set,
  output logic               mmu_req,
  output logic               issue_valid,
  input  logic               issue_ready,
  output logic [INSTR_W-1:0] issue_instr,
  input  logic               wb_valid,
  input  logic [NREGS-1:0]   wb_mask,
  input  logic               wb_flags,
  output logic [NREGS-1:0]   busy_mask,
  output logic               stall,
  output logic               retire,
  output logic               mmu_err
);
  localparam int TW = $clog2(MMU_TIMEOUT + 1);
  typedef enum logic [2:0] {IDLE, CHECK, MMU_WAIT, ISSUE, ERROR} state_t;
  state_t r_state;
  logic [INSTR_W-1:0] r_instr;
  logic [NREGS-1:0] r_src, r_busy;
  logic r_flags_busy;
  logic [TW-1:0] r_tmo;
  logic w_hazard, w_hs, w_fset, w_fclr, w_mem;
  logic [NREGS-1:0] w_set, w_clr;
  assign w_hazard = (|(r_src & r_busy)) || (|(ds2_regs_set & r_busy)) || (ds2_flags && r_flags_busy);
  assign w_hs = r_state == ISSUE && issue_ready;
  assign w_set = w_hs ? ds2_regs_set : '0;
  assign w_clr = wb_valid ? wb_mask : '0;
  assign w_fset = w_hs && ds2_flags;
  assign w_fclr = wb_valid && wb_flags;
  assign w_mem = r_instr[INSTR_W-1 -: 3] == 3'b001;
  assign in_ready = r_state == IDLE;
  assign ds2_instr = r_instr;
  assign issue_instr = r_instr;
  assign mmu_req = r_state == MMU_WAIT;
  assign issue_valid = r_state == ISSUE;
  assign mmu_err = r_state == ERROR;
  assign busy_mask = r_busy;
  assign stall = r_state == CHECK && w_hazard;
  assign retire = (r_state == CHECK && !w_hazard && ds2_finished) ||
                  (r_state == MMU_WAIT && ds2_ready && ds2_finished);
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_instr <= '0;
      r_src <= '0;
      r_busy <= '0;
      r_flags_busy <= 1'b0;
      r_tmo <= '0;
    end else begin
      r_busy <= ((r_busy | w_set) & ~w_clr) | w_set;
      r_flags_busy <= (r_flags_busy && !w_fclr) || w_fset;
      case (r_state)
        IDLE: if (in_valid) begin
          r_instr <= in_instr;
          r_src <= in_src_mask;
          r_state <= CHECK;
        end
        CHECK: begin
          r_tmo <= '0;
          if (!w_hazard) r_state <= ds2_finished ? IDLE : (w_mem ? MMU_WAIT : ISSUE);
        end
        MMU_WAIT: begin
          if (ds2_ready) r_state <= ds2_finished ? IDLE : ISSUE;
          else if (r_tmo == TW'(MMU_TIMEOUT - 1)) r_state <= ERROR;
          else r_tmo <= r_tmo + 1'b1;
        end
        ISSUE: if (issue_ready) r_state <= IDLE;
        default: r_state <= ERROR;
      endcase
    end
  end
endmodule

// File: tb/tb_id_issue_ctrl.sv
// tb_id_issue_ctrl: directed and randomized checks of id_issue_ctrl against a behavioural model
module tb_id_issue_ctrl;
  localparam int INSTR_W = 24;
  localparam int NREGS = 8;
  localparam int MMU_TIMEOUT = 255;
  localparam int P_IDLE = 0, P_CHECK = 1, P_MMU = 2, P_ISSUE = 3, P_ERR = 4;
  logic clk = 1'b0;
  logic rst_n, in_valid, in_ready, ds2_ready, ds2_finished, ds2_flags, mmu_req;
  logic issue_valid, issue_ready, wb_valid, wb_flags, stall, retire, mmu_err;
  logic [INSTR_W-1:0] in_instr, ds2_instr, issue_instr;
  logic [NREGS-1:0] in_src_mask, ds2_regs_set, wb_mask, busy_mask;
  int n_vec = 0, n_err = 0;
  int m_ph = P_IDLE;
  int m_waited = 0;
  logic [INSTR_W-1:0] m_instr = '0;
  logic [NREGS-1:0] m_src = '0;
  bit m_busy [NREGS];
  bit m_fbusy = 1'b0;
  bit m_on = 1'b0;
  id_issue_ctrl #(.INSTR_W(INSTR_W), .NREGS(NREGS), .MMU_TIMEOUT(MMU_TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_instr(in_instr), .in_src_mask(in_src_mask),
    .in_ready(in_ready), .ds2_instr(ds2_instr), .ds2_ready(ds2_ready), .ds2_finished(ds2_finished),
    .ds2_flags(ds2_flags), .ds2_regs_set(ds2_regs_set), .mmu_req(mmu_req), .issue_valid(issue_valid),
    .issue_ready(issue_ready), .issue_instr(issue_instr), .wb_valid(wb_valid), .wb_mask(wb_mask),
    .wb_flags(wb_flags), .busy_mask(busy_mask), .stall(stall), .retire(retire), .mmu_err(mmu_err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  function automatic logic [NREGS-1:0] busy_vec();
    logic [NREGS-1:0] v = '0;
    for (int r = 0; r < NREGS; r++) v[r] = m_busy[r];
    return v;
  endfunction
  always @(negedge clk) begin
    automatic logic hz = ds2_flags && m_fbusy;
    automatic logic hs = m_ph == P_ISSUE && issue_ready;
    automatic logic mem = m_instr[23:21] == 3'b001;
    for (int r = 0; r < NREGS; r++) if ((m_src[r] || ds2_regs_set[r]) && m_busy[r]) hz = 1'b1;
    if (m_on) begin
      chk("in_ready", 32'(in_ready), 32'(m_ph == P_IDLE));
      chk("stall", 32'(stall), 32'(m_ph == P_CHECK && hz));
      chk("retire", 32'(retire), 32'((m_ph == P_CHECK && !hz && ds2_finished) ||
                                     (m_ph == P_MMU && ds2_ready && ds2_finished)));
      chk("mmu_req", 32'(mmu_req), 32'(m_ph == P_MMU));
      chk("issue_valid", 32'(issue_valid), 32'(m_ph == P_ISSUE));
      chk("mmu_err", 32'(mmu_err), 32'(m_ph == P_ERR));
      chk("ds2_instr", 32'(ds2_instr), 32'(m_instr));
      chk("issue_instr", 32'(issue_instr), 32'(m_instr));
      chk("busy_mask", 32'(busy_mask), 32'(busy_vec()));
    end
    if (!rst_n) begin
      m_ph <= P_IDLE;
      m_instr <= '0;
      m_src <= '0;
      for (int r = 0; r < NREGS; r++) m_busy[r] <= 1'b0;
      m_fbusy <= 1'b0;
      m_waited <= 0;
      m_on <= 1'b1;
    end else if (m_on) begin
      for (int r = 0; r < NREGS; r++)
        m_busy[r] <= (hs && ds2_regs_set[r]) ? 1'b1 : (wb_valid && wb_mask[r]) ? 1'b0 : m_busy[r];
      m_fbusy <= (hs && ds2_flags) ? 1'b1 : (wb_valid && wb_flags) ? 1'b0 : m_fbusy;
      case (m_ph)
        P_IDLE: if (in_valid) begin
          m_instr <= in_instr;
          m_src <= in_src_mask;
          m_ph <= P_CHECK;
        end
        P_CHECK: if (!hz) begin
          m_waited <= 0;
          m_ph <= ds2_finished ? P_IDLE : mem ? P_MMU : P_ISSUE;
        end
        P_MMU: begin
          if (ds2_ready) m_ph <= ds2_finished ? P_IDLE : P_ISSUE;
          else if (m_waited + 1 == MMU_TIMEOUT) m_ph <= P_ERR;
          else m_waited <= m_waited + 1;
        end
        P_ISSUE: if (issue_ready) m_ph <= P_IDLE;
        default: m_ph <= P_ERR;
      endcase
    end
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic idle_in();
    in_valid = 0; in_instr = '0; in_src_mask = '0; ds2_ready = 0; ds2_finished = 0; ds2_flags = 0;
    ds2_regs_set = '0; issue_ready = 0; wb_valid = 0; wb_mask = '0; wb_flags = 0;
  endtask
  initial begin
    int cnt;
    logic [2:0] ops [4] = '{3'b001, 3'b100, 3'b000, 3'b011};
    idle_in();
    rst_n = 0;
    step();
    step();
    rst_n = 1;
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_busy", 32'(busy_mask), 32'd0);
    chk("rst_outs", 32'({issue_valid, mmu_req, mmu_err, stall, retire}), 32'd0);
    chk("rst_instr", 32'(ds2_instr), 32'd0);
    in_valid = 1; in_instr = 24'h812300; ds2_regs_set = 8'h23; issue_ready = 1;
    #1 chk("alu_accept", 32'(in_ready), 32'd1);
    step(); in_valid = 0;
    #1 chk("alu_check_no_issue", 32'(issue_valid), 32'd0);
    step();
    #1 chk("alu_issue_valid", 32'(issue_valid), 32'd1);
    chk("alu_issue_instr", 32'(issue_instr), 32'h812300);
    step();
    #1 chk("alu_busy", 32'(busy_mask), 32'h23);
    chk("model_busy", 32'(busy_vec()), 32'h23);
    ds2_regs_set = '0; in_valid = 1; in_instr = 24'h812301; in_src_mask = 8'h02;
    step(); in_valid = 0;
    #1 chk("raw_stall", 32'(stall), 32'd1);
    step();
    #1 chk("raw_stall_hold", 32'(stall), 32'd1);
    wb_valid = 1; wb_mask = 8'h02;
    step(); wb_valid = 0; wb_mask = '0;
    #1 chk("raw_stall_drop", 32'(stall), 32'd0);
    chk("raw_busy_clr", 32'(busy_mask), 32'h21);
    step();
    #1 chk("raw_issue", 32'(issue_valid), 32'd1);
    step();
    in_valid = 1; in_instr = 24'h2abcde; in_src_mask = '0; issue_ready = 0;
    step(); in_valid = 0;
    step();
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      ds2_ready = i >= 5;
      #1;
      if (!mmu_req) break;
      cnt++;
      step();
    end
    chk("mmu_req_cycles", 32'(cnt), 32'd6);
    chk("mmu_then_issue", 32'(issue_valid), 32'd1);
    ds2_ready = 0; issue_ready = 1;
    step();
    #1 chk("mmu_done_idle", 32'(in_ready), 32'd1);
    in_valid = 1; in_instr = 24'h312345;
    step(); in_valid = 0; ds2_finished = 1;
    #1 chk("fin_retire", 32'(retire), 32'd1);
    chk("fin_no_issue", 32'(issue_valid), 32'd0);
    step(); ds2_finished = 0;
    #1 chk("fin_idle", 32'(in_ready), 32'd1);
    chk("fin_retire_pulse", 32'(retire), 32'd0);
    in_valid = 1; in_instr = 24'h812000; ds2_regs_set = 8'h10;
    step(); in_valid = 0;
    step(); wb_valid = 1; wb_mask = 8'h10;
    step(); wb_valid = 0; wb_mask = '0; ds2_regs_set = '0;
    #1 chk("set_wins", 32'(busy_mask), 32'h31);
    chk("model_set_wins", 32'(busy_vec()), 32'h31);
    in_valid = 1; in_instr = 24'h012345;
    step(); in_valid = 0; ds2_finished = 1;
    #1 chk("op0_retire", 32'(retire), 32'd1);
    step(); ds2_finished = 0;
    #1 chk("op0_busy_kept", 32'(busy_mask), 32'h31);
    in_valid = 1; in_instr = 24'h212345; ds2_ready = 0;
    step(); in_valid = 0;
    step();
    cnt = 0;
    for (int i = 0; i < 400; i++) begin
      #1;
      if (!mmu_req) break;
      cnt++;
      step();
    end
    chk("tmo_cycles", 32'(cnt), 32'(MMU_TIMEOUT));
    chk("tmo_err", 32'(mmu_err), 32'd1);
    chk("tmo_in_ready", 32'(in_ready), 32'd0);
    repeat (3) step();
    #1 chk("err_sticky", 32'(mmu_err), 32'd1);
    rst_n = 0;
    step(); rst_n = 1;
    #1 chk("rerst_in_ready", 32'(in_ready), 32'd1);
    chk("rerst_err", 32'(mmu_err), 32'd0);
    chk("rerst_busy", 32'(busy_mask), 32'd0);
    chk("rerst_instr", 32'(ds2_instr), 32'd0);
    for (int i = 0; i < 3000; i++) begin
      step();
      rst_n = $urandom_range(0, 299) != 0;
      in_valid = $urandom_range(0, 1) != 0;
      in_instr = {ops[$urandom_range(0, 3)], 21'($urandom())};
      in_src_mask = 8'($urandom() & $urandom() & $urandom());
      ds2_regs_set = 8'($urandom() & $urandom());
      ds2_flags = $urandom_range(0, 3) == 0;
      ds2_ready = $urandom_range(0, 2) != 0;
      ds2_finished = $urandom_range(0, 3) == 0;
      issue_ready = $urandom_range(0, 2) != 0;
      wb_valid = $urandom_range(0, 1) != 0;
      wb_mask = 8'($urandom());
      wb_flags = $urandom_range(0, 1) != 0;
    end
    step();
    rst_n = 1;
    idle_in();
    step();
    step();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
